// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among NREQ requesters,
// with a single-entry tagged result register and valid/ready backpressure.
//   state | meaning
//   EMPTY | result register holds nothing, any winner may be accepted
//   FULL  | result register holds rsp_data/rsp_id, refill only if drained
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic [15:0]           busy_cycles
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [15:0]      busy_q, busy_d;
  logic [IDW-1:0]   winner;
  logic             found;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] a_sel, b_sel, result;
  logic [1:0]       op_sel;

  // Search upward from ptr with wrap-around; first valid requester wins.
  always_comb begin : grant_search
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign can_accept = (state_q == EMPTY) || rsp_ready;
  // Gating with rst_n keeps req_ready low while reset is asserted.
  assign xfer       = rst_n && found && can_accept;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[winner] = 1'b1;
  end

  assign a_sel  = req_a[int'(winner)*WIDTH +: WIDTH];
  assign b_sel  = req_b[int'(winner)*WIDTH +: WIDTH];
  assign op_sel = req_op[int'(winner)*2 +: 2];

  always_comb begin
    result = '0;
    case (op_sel)
      2'b00:   result = a_sel & b_sel;
      2'b01:   result = a_sel | b_sel;
      2'b10:   result = a_sel ^ b_sel;
      default: result = ~(a_sel | b_sel);
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    if (xfer) begin
      state_d = FULL;
      data_d  = result;
      id_d    = winner;
      ptr_d   = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
    if (state_q == FULL && !rsp_ready && busy_q != 16'hFFFF) begin
      busy_d = busy_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign rsp_valid   = (state_q == FULL);
  assign rsp_data    = data_q;
  assign rsp_id      = id_q;
  assign busy_cycles = busy_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: opcode table, directed corner
// sequences and randomized traffic against a transaction-level model.
module tb_logic_unit_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*2-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic [15:0]           busy_cycles;

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .busy_cycles(busy_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the result register as a transaction record.
  bit         m_full;
  logic [31:0] m_data;
  int         m_id;
  int         m_ptr;
  int         m_busy;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] exp;
  } op_vec_t;
  op_vec_t vecs[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] opres(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_op[i*2 +: 2]        = op;
  endtask

  task automatic model_reset();
    m_full = 0; m_data = '0; m_id = 0; m_ptr = 0; m_busy = 0;
  endtask

  // Called with clk low and inputs settled; checks one full cycle.
  task automatic step(output logic [NREQ-1:0] acc);
    int  w;
    bit  stall;
    logic [NREQ-1:0] exp_rdy;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    end
    exp_rdy = '0;
    if (w >= 0 && (!m_full || rsp_ready)) exp_rdy[w] = 1'b1;
    #1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    stall = m_full && !rsp_ready;
    @(posedge clk);
    if (exp_rdy != '0) begin
      m_data = opres(req_a[w*WIDTH +: WIDTH], req_b[w*WIDTH +: WIDTH], req_op[w*2 +: 2]);
      m_id   = w;
      m_full = 1;
      m_ptr  = (w + 1) % NREQ;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    if (stall && m_busy < 65535) m_busy++;
    acc = exp_rdy;
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
    chk("rsp_data", 64'(rsp_data), 64'(m_data));
    chk("rsp_id", 64'(rsp_id), 64'(m_id));
    chk("busy_cycles", 64'(busy_cycles), 64'(m_busy));
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_busy", 64'(busy_cycles), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] acc;
    int pulses[NREQ];

    vecs[0] = '{2'b00, 32'h00F0_1234};
    vecs[1] = '{2'b01, 32'hFFF0_FFFF};
    vecs[2] = '{2'b10, 32'hFF00_EDCB};
    vecs[3] = '{2'b11, 32'h000F_0000};

    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    model_reset();
    do_reset();

    // Reset mid-stream while FULL, with requests pending.
    set_req(0, 32'h1234_5678, 32'hFFFF_0000, 2'b01);
    req_valid = 4'b0001;
    step(acc);
    req_valid = 4'b0101;
    step(acc);
    chk("pre_reset_full", 64'(rsp_valid), 64'd1);
    do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) step(acc);

    // Opcode table on requester 2.
    for (int v = 0; v < 4; v++) begin
      set_req(2, 32'hF0F0_1234, 32'h0FF0_FFFF, vecs[v].op);
      req_valid = 4'b0100;
      step(acc);
      chk($sformatf("op%0d_data", v), 64'(rsp_data), 64'(vecs[v].exp));
      chk($sformatf("op%0d_id", v), 64'(rsp_id), 64'd2);
    end
    req_valid = '0;
    step(acc);

    // Round-robin with all requesters valid.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 32'(i * 32'h1111_1111), 32'hA5A5_5A5A, 2'(i));
      pulses[i] = 0;
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      step(acc);
      chk("rr_id", 64'(rsp_id), 64'(t % NREQ));
      for (int i = 0; i < NREQ; i++) if (acc[i]) pulses[i]++;
    end
    for (int i = 0; i < NREQ; i++) chk($sformatf("rr_pulses%0d", i), 64'(pulses[i]), 64'd2);

    // Backpressure: stall 5 cycles with requesters 1 and 3 waiting.
    do_reset();
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    step(acc);
    req_valid = 4'b1010;
    for (int t = 0; t < 5; t++) begin
      step(acc);
      chk("stall_id", 64'(rsp_id), 64'd1);
      chk("stall_data", 64'(rsp_data), 64'(opres(32'h1111_1111, 32'hA5A5_5A5A, 2'b01)));
    end
    chk("stall_busy", 64'(busy_cycles), 64'd5);
    rsp_ready = 1'b1;
    #1;
    chk("refill_same_cycle", 64'(req_ready), 64'b1000);
    step(acc);
    chk("refill_id", 64'(rsp_id), 64'd3);

    // Drain without refill, then pointer hold.
    do_reset();
    req_valid = 4'b0010;
    step(acc);
    req_valid = '0;
    step(acc);
    chk("drain_valid", 64'(rsp_valid), 64'd0);
    chk("drain_id_hold", 64'(rsp_id), 64'd1);
    step(acc);
    step(acc);
    req_valid = 4'b0101;
    #1;
    chk("ptr_hold_ready", 64'(req_ready), 64'b0100);
    step(acc);
    chk("ptr_hold_id", 64'(rsp_id), 64'd2);

    // Randomized traffic; requesters hold until accepted.
    req_valid = '0;
    acc = '0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          set_req(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step(acc);
    end

    // Saturation of busy_cycles.
    do_reset();
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    step(acc);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("sat_busy", 64'(busy_cycles), 64'hFFFF);
    chk("sat_valid", 64'(rsp_valid), 64'd1);
    m_busy = 65535;
    step(acc);
    chk("sat_no_wrap", 64'(busy_cycles), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
